// File: rtl/debounced_updown_counter.sv
// Debounced up/down/clear push-button counter with LED mirror and bound pulse.
// Define BTN_AUTOREPEAT_EN for auto-repeat on held up/down (RPT_DELAY, RPT_PERIOD >= 2).
module debounced_updown_counter #(
    parameter int WIDTH        = 4,
    parameter int DB_THRESHOLD = 300,
    parameter int SATURATE     = 0,
    parameter int RPT_DELAY    = 5000,
    parameter int RPT_PERIOD   = 1000
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_clear,
    output logic [WIDTH-1:0] count,
    output logic [3:0]       led,
    output logic             limit_hit
);
    localparam int N_BTN = 3;
    localparam int DBW = $clog2(DB_THRESHOLD);
    localparam logic [WIDTH-1:0] MAX_COUNT = '1;

    logic [N_BTN-1:0] rawBtn;
    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;
    logic [N_BTN-1:0] stable_q;
    logic [N_BTN-1:0] stable_d;
    logic [N_BTN-1:0] stableDly_q;
    logic [N_BTN-1:0] press_q;
    logic [DBW-1:0]   dbCnt_q [N_BTN];
    logic [DBW-1:0]   dbCnt_d [N_BTN];

    logic             upStep;
    logic             downStep;
    logic             clearStep;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [3:0]       led_q;
    logic             limit_q;
    logic             limit_d;

    assign rawBtn = {btn_clear, btn_down, btn_up};

    // A new level is accepted on the DB_THRESHOLD-th consecutive differing sample.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            stable_d[i] = stable_q[i];
            dbCnt_d[i]  = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (dbCnt_q[i] == DBW'(DB_THRESHOLD - 1)) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    dbCnt_d[i] = dbCnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            stable_q    <= '0;
            stableDly_q <= '0;
            press_q     <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                dbCnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= rawBtn;
            sync2_q     <= sync1_q;
            stable_q    <= stable_d;
            stableDly_q <= stable_q;
            press_q     <= stable_q & ~stableDly_q;
            for (int i = 0; i < N_BTN; i++) begin
                dbCnt_q[i] <= dbCnt_d[i];
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int RPW = $clog2(RPT_MAX + 1);

    logic [RPW-1:0] rptCnt_q [2];
    logic [1:0]     rptFirst_q;
    logic [1:0]     rpt_q;

    // rptCnt_q counts cycles since the last step event; a release cancels the pending repeat.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            rptFirst_q <= '0;
            rpt_q      <= '0;
            for (int i = 0; i < 2; i++) begin
                rptCnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                rpt_q[i] <= stable_q[i] & stable_d[i] & ~(press_q[i] | rpt_q[i])
                            & (rptCnt_q[i] == (rptFirst_q[i] ? RPW'(RPT_DELAY - 1)
                                                             : RPW'(RPT_PERIOD - 1)));
                if (!stable_q[i]) begin
                    rptCnt_q[i] <= '0;
                end else if (press_q[i] | rpt_q[i]) begin
                    rptCnt_q[i]   <= RPW'(1);
                    rptFirst_q[i] <= press_q[i];
                end else begin
                    rptCnt_q[i] <= rptCnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign upStep   = press_q[0] | rpt_q[0];
    assign downStep = press_q[1] | rpt_q[1];
`else
    logic unusedRptParams;
    assign unusedRptParams = ^{RPT_DELAY, RPT_PERIOD};
    assign upStep   = press_q[0];
    assign downStep = press_q[1];
`endif
    assign clearStep = press_q[2];

    always_comb begin
        count_d = count_q;
        limit_d = 1'b0;
        if (clearStep) begin
            count_d = '0;
        end else if (upStep && !downStep) begin
            if (count_q == MAX_COUNT) begin
                limit_d = 1'b1;
                count_d = (SATURATE != 0) ? MAX_COUNT : '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (downStep && !upStep) begin
            if (count_q == '0) begin
                limit_d = 1'b1;
                count_d = (SATURATE != 0) ? '0 : MAX_COUNT;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            led_q   <= '0;
            limit_q <= 1'b0;
        end else begin
            count_q <= count_d;
            led_q   <= count_d[3:0];
            limit_q <= limit_d;
        end
    end

    assign count     = count_q;
    assign led       = led_q;
    assign limit_hit = limit_q;
endmodule
